// File: rtl/irq_handshake_ctrl.sv
// Multi-channel interrupt handshake controller: per-channel sync/edge-detect, sticky pending,
// fixed-priority arbitration onto one CPU interrupt line. Define IRQ_OVERRUN_CNT_EN for overrun tracking.
module irq_handshake_ctrl #(
    parameter int NUM_CH      = 4,
    parameter int ID_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF_CYC = 2,
    parameter int OVR_W       = 4
) (
    input  logic                    clk50,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       req_async,
    input  logic [NUM_CH-1:0]       irq_mask,
    input  logic                    IO_INT_ACK,
    input  logic                    ovr_clr,
    output logic                    interrupt,
    output logic [ID_W-1:0]         irq_id,
    output logic [NUM_CH-1:0]       pending,
    output logic [NUM_CH-1:0]       overrun,
    output logic [NUM_CH*OVR_W-1:0] ovr_count
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ASSERT  = 2'd1;
    localparam logic [1:0] ST_HOLDOFF = 2'd2;

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] prev_q;
    logic [NUM_CH-1:0] mask_q;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] clr_vec;
    logic [NUM_CH-1:0] pend_nxt;
    logic [1:0]        state;
    logic [3:0]        hold_cnt;
    logic              ack_fire;
    logic              any_req;
    logic [ID_W-1:0]   sel_id;

    always_ff @(posedge clk50) begin
        if (reset) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= req_async;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise     = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign ack_fire = (state == ST_ASSERT) && IO_INT_ACK;
    // A new edge on the channel being acked keeps it pending (set wins over clear)
    assign pend_nxt = (pending & ~clr_vec) | rise;

    always_comb begin
        clr_vec = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            clr_vec[i] = ack_fire && (irq_id == ID_W'(i));
        end
    end

    always_comb begin
        any_req = 1'b0;
        sel_id  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!any_req && pending[i] && mask_q[i]) begin
                any_req = 1'b1;
                sel_id  = ID_W'(i);
            end
        end
    end

    // Mask is registered so arbitration sees no direct path from irq_mask
    always_ff @(posedge clk50) begin
        if (reset) begin
            state     <= ST_IDLE;
            interrupt <= 1'b0;
            irq_id    <= '0;
            hold_cnt  <= '0;
            pending   <= '0;
            mask_q    <= '0;
        end else begin
            pending <= pend_nxt;
            mask_q  <= irq_mask;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        irq_id    <= sel_id;
                        interrupt <= 1'b1;
                        state     <= ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    if (IO_INT_ACK) begin
                        interrupt <= 1'b0;
                        hold_cnt  <= 4'(HOLDOFF_CYC - 1);
                        state     <= ST_HOLDOFF;
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_cnt == 4'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    interrupt <= 1'b0;
                end
            endcase
        end
    end

`ifdef IRQ_OVERRUN_CNT_EN
    logic [NUM_CH-1:0] ovr_evt;
    logic [OVR_W-1:0]  cnt_q [NUM_CH];

    assign ovr_evt = rise & pending & ~clr_vec;

    always_ff @(posedge clk50) begin
        if (reset) begin
            overrun <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (ovr_clr) begin
                    overrun[i] <= ovr_evt[i];
                    cnt_q[i]   <= ovr_evt[i] ? OVR_W'(1) : '0;
                end else if (ovr_evt[i]) begin
                    overrun[i] <= 1'b1;
                    if (cnt_q[i] != '1) begin
                        cnt_q[i] <= cnt_q[i] + OVR_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        ovr_count = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ovr_count[i*OVR_W +: OVR_W] = cnt_q[i];
        end
    end
`else
    logic unused_ovr_clr;

    assign unused_ovr_clr = ovr_clr;
    assign overrun        = '0;
    assign ovr_count      = '0;
`endif

endmodule

// File: tb/tb_irq_handshake_ctrl.sv
// Directed self-checking bench for irq_handshake_ctrl (NUM_CH=4, SYNC_STAGES=2, HOLDOFF_CYC=2, OVR_W=4).
module tb_irq_handshake_ctrl;

    logic        clk50 = 1'b0;
    logic        reset;
    logic [3:0]  req_async;
    logic [3:0]  irq_mask;
    logic        IO_INT_ACK;
    logic        ovr_clr;
    logic        interrupt;
    logic [1:0]  irq_id;
    logic [3:0]  pending;
    logic [3:0]  overrun;
    logic [15:0] ovr_count;

    int errors = 0;
    int checks = 0;

    irq_handshake_ctrl #(
        .NUM_CH(4), .ID_W(2), .SYNC_STAGES(2), .HOLDOFF_CYC(2), .OVR_W(4)
    ) dut (
        .clk50(clk50), .reset(reset), .req_async(req_async), .irq_mask(irq_mask),
        .IO_INT_ACK(IO_INT_ACK), .ovr_clr(ovr_clr), .interrupt(interrupt),
        .irq_id(irq_id), .pending(pending), .overrun(overrun), .ovr_count(ovr_count)
    );

    always #10 clk50 = ~clk50;

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk50);
        #1;
    endtask

    task automatic pulse_req(input logic [3:0] ch);
        req_async = ch;
        tick; tick;
        req_async = '0;
        tick; tick;
    endtask

    task automatic test_reset;
        reset = 1'b1; req_async = '0; irq_mask = 4'hF; IO_INT_ACK = 1'b0; ovr_clr = 1'b0;
        repeat (3) tick;
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL reset_int: got %b want 0", interrupt); end
        checks++; if (irq_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", irq_id); end
        checks++; if (pending !== 4'b0) begin errors++; $display("FAIL reset_pend: got %b want 0000", pending); end
        checks++; if (overrun !== 4'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0000", overrun); end
        checks++; if (ovr_count !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0000", ovr_count); end
        req_async = 4'b0010; irq_mask = 4'h0;
        repeat (2) tick;
        reset = 1'b0;
        tick;
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL rel_pend_e0: got %b want 0000", pending); end
        tick; tick;
        checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL rel_pend_e2: got %b want 0010", pending); end
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL rel_masked_int: got %b want 0", interrupt); end
        req_async = '0; reset = 1'b1;
        tick;
        reset = 1'b0; irq_mask = 4'hF;
        tick; tick;
    endtask

    task automatic test_basic;
        req_async = 4'b0100;
        tick; tick;
        req_async = '0;
        tick;
        checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL basic_pend: got %b want 0100", pending); end
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL basic_int_early: got %b want 0", interrupt); end
        tick;
        checks++; if (interrupt !== 1'b1 || irq_id !== 2'd2) begin errors++; $display("FAIL basic_assert: got int=%b id=%0d want int=1 id=2", interrupt, irq_id); end
        IO_INT_ACK = 1'b1; tick; IO_INT_ACK = 1'b0;
        checks++; if (interrupt !== 1'b0 || pending !== 4'b0) begin errors++; $display("FAIL basic_ack: got int=%b pend=%b want int=0 pend=0000", interrupt, pending); end
        tick;
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL basic_hold1: got %b want 0", interrupt); end
        tick;
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL basic_hold2: got %b want 0", interrupt); end
        tick;
    endtask

    task automatic test_priority;
        req_async = 4'b1010;
        tick; tick;
        req_async = '0;
        tick;
        checks++; if (pending !== 4'b1010) begin errors++; $display("FAIL prio_pend: got %b want 1010", pending); end
        tick;
        checks++; if (interrupt !== 1'b1 || irq_id !== 2'd1) begin errors++; $display("FAIL prio_first: got int=%b id=%0d want int=1 id=1", interrupt, irq_id); end
        IO_INT_ACK = 1'b1; tick;
        checks++; if (interrupt !== 1'b0 || pending !== 4'b1000) begin errors++; $display("FAIL prio_ack1: got int=%b pend=%b want int=0 pend=1000", interrupt, pending); end
        tick; IO_INT_ACK = 1'b0;
        checks++; if (interrupt !== 1'b0 || pending !== 4'b1000) begin errors++; $display("FAIL prio_hold_ack_ignored: got int=%b pend=%b want int=0 pend=1000", interrupt, pending); end
        tick;
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL prio_hold2: got %b want 0", interrupt); end
        tick;
        checks++; if (interrupt !== 1'b1 || irq_id !== 2'd3) begin errors++; $display("FAIL prio_second: got int=%b id=%0d want int=1 id=3", interrupt, irq_id); end
        IO_INT_ACK = 1'b1; tick; IO_INT_ACK = 1'b0;
        checks++; if (interrupt !== 1'b0 || pending !== 4'b0000) begin errors++; $display("FAIL prio_ack2: got int=%b pend=%b want int=0 pend=0000", interrupt, pending); end
        repeat (3) tick;
    endtask

    task automatic test_mask;
        irq_mask = 4'b1110;
        req_async = 4'b0001;
        tick; tick;
        req_async = '0;
        tick;
        checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL mask_pend: got %b want 0001", pending); end
        tick; tick;
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL mask_blocked: got %b want 0", interrupt); end
        irq_mask = 4'hF;
        tick; tick;
        checks++; if (interrupt !== 1'b1 || irq_id !== 2'd0) begin errors++; $display("FAIL mask_enable: got int=%b id=%0d want int=1 id=0", interrupt, irq_id); end
        irq_mask = 4'h0;
        tick; tick;
        checks++; if (interrupt !== 1'b1 || irq_id !== 2'd0) begin errors++; $display("FAIL mask_hold_assert: got int=%b id=%0d want int=1 id=0", interrupt, irq_id); end
        irq_mask = 4'hF;
        IO_INT_ACK = 1'b1; tick; IO_INT_ACK = 1'b0;
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL mask_ack: got %b want 0000", pending); end
        repeat (3) tick;
    endtask

    task automatic test_overrun;
        logic [3:0]  exp_ovr;
        logic [15:0] exp_cnt;
        repeat (3) pulse_req(4'b0100);
`ifdef IRQ_OVERRUN_CNT_EN
        exp_ovr = 4'b0100; exp_cnt = 16'h0200;
`else
        exp_ovr = 4'b0000; exp_cnt = 16'h0000;
`endif
        checks++; if (interrupt !== 1'b1 || irq_id !== 2'd2) begin errors++; $display("FAIL ovr_assert: got int=%b id=%0d want int=1 id=2", interrupt, irq_id); end
        checks++; if (overrun !== exp_ovr) begin errors++; $display("FAIL ovr_flag: got %b want %b", overrun, exp_ovr); end
        checks++; if (ovr_count !== exp_cnt) begin errors++; $display("FAIL ovr_count2: got %h want %h", ovr_count, exp_cnt); end
        repeat (20) pulse_req(4'b0100);
`ifdef IRQ_OVERRUN_CNT_EN
        exp_cnt = 16'h0F00;
`endif
        checks++; if (ovr_count !== exp_cnt) begin errors++; $display("FAIL ovr_sat: got %h want %h", ovr_count, exp_cnt); end
        checks++; if (overrun !== exp_ovr) begin errors++; $display("FAIL ovr_flag_sat: got %b want %b", overrun, exp_ovr); end
        ovr_clr = 1'b1; tick; ovr_clr = 1'b0;
        checks++; if (overrun !== 4'b0 || ovr_count !== 16'h0) begin errors++; $display("FAIL ovr_clr: got ovr=%b cnt=%h want 0000/0000", overrun, ovr_count); end
        IO_INT_ACK = 1'b1; tick; IO_INT_ACK = 1'b0;
        checks++; if (pending !== 4'b0000 || interrupt !== 1'b0) begin errors++; $display("FAIL ovr_ack: got pend=%b int=%b want 0000/0", pending, interrupt); end
        repeat (3) tick;
    endtask

    task automatic test_set_clear;
        req_async = 4'b0001;
        tick; tick;
        req_async = '0;
        tick; tick;
        checks++; if (interrupt !== 1'b1 || irq_id !== 2'd0) begin errors++; $display("FAIL sc_assert: got int=%b id=%0d want int=1 id=0", interrupt, irq_id); end
        tick; tick;
        req_async = 4'b0001;
        tick; tick;
        req_async = '0;
        IO_INT_ACK = 1'b1; tick; IO_INT_ACK = 1'b0;
        checks++; if (interrupt !== 1'b0 || pending !== 4'b0001) begin errors++; $display("FAIL sc_setwins: got int=%b pend=%b want int=0 pend=0001", interrupt, pending); end
        checks++; if (overrun !== 4'b0 || ovr_count !== 16'h0) begin errors++; $display("FAIL sc_no_ovr: got ovr=%b cnt=%h want 0000/0000", overrun, ovr_count); end
        tick; tick;
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL sc_hold: got %b want 0", interrupt); end
        tick;
        checks++; if (interrupt !== 1'b1 || irq_id !== 2'd0) begin errors++; $display("FAIL sc_reassert: got int=%b id=%0d want int=1 id=0", interrupt, irq_id); end
        IO_INT_ACK = 1'b1; tick; IO_INT_ACK = 1'b0;
        repeat (3) tick;
    endtask

    task automatic test_reset_mid_assert;
        req_async = 4'b0010;
        tick; tick;
        req_async = '0;
        tick; tick;
        checks++; if (interrupt !== 1'b1 || irq_id !== 2'd1) begin errors++; $display("FAIL rma_assert: got int=%b id=%0d want int=1 id=1", interrupt, irq_id); end
        reset = 1'b1; tick; reset = 1'b0;
        checks++; if (interrupt !== 1'b0 || pending !== 4'b0 || irq_id !== 2'd0) begin errors++; $display("FAIL rma_reset: got int=%b pend=%b id=%0d want 0/0000/0", interrupt, pending, irq_id); end
        tick; tick; tick;
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL rma_after: got %b want 0", interrupt); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_priority;
        test_mask;
        test_overrun;
        test_set_clear;
        test_reset_mid_assert;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
